fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls program_counter_unit: generates PCSrc and the PC write enable.
- Arbitrates redirect requests from ID (jump, jr) and EX (branch).
- Holds a redirect pending across icache misses and hazard stalls, and produces fetch-stage flushes.
- Sits between the hazard unit / control logic and the PC unit in the fetch stage.

Parameters:
WAIT_MAX, 64, ihit-low cycles tolerated in WAIT before fetch_timeout sets (>=2)
CNT_W, 7, width of the internal wait counter; must hold WAIT_MAX

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction fetch complete this cycle
stall  input  1  hazard-unit stall of fetch/decode
halt  input  1  halt decoded; terminal
br_req  input  1  EX: branch taken (single-cycle pulse)
jr_req  input  1  ID: jr decoded (pulse)
j_req  input  1  ID: j/jal decoded (pulse)
PCSrc  output  2  to PC unit: 0=PC+4, 1=branch, 2=jump(jaddr), 3=jr(reg31)
pc_en  output  1  PC register write enable
imemREN  output  1  instruction memory read enable
if_flush  output  1  squash IF/ID latch
id_flush  output  1  squash ID/EX latch (branch redirects only)
fetch_timeout  output  1  sticky: ihit stuck low in WAIT
busy  output  1  redirect pending (state WAIT)

Behaviour:
- Interface: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values:
  - State RUN; pending source = 0; wait counter = 0.
  - PCSrc=0, pc_en=0, imemREN=1, if_flush=0, id_flush=0, fetch_timeout=0, busy=0.
  - Reset mid-WAIT discards the pending redirect.
- Request priority, same cycle: br_req > jr_req > j_req. Encoded source: br=1, j=2, jr=3. Priority rank is by request, not by code value.
- Outputs are combinational from state plus inputs. State, pending register and counter are registered.
- RUN:
  - go = ihit & ~stall.
  - No request: PCSrc=0, pc_en=go.
  - Request and go: PCSrc = winning source, pc_en=1, if_flush=1, id_flush=(winner==br). Stay in RUN.
  - Request and ~go: latch winner into pending, enter WAIT. PCSrc=0, pc_en=0, no flush this cycle.
- WAIT:
  - busy=1, PCSrc=pending.
  - When go: pc_en=1, if_flush=1, id_flush=(pending==br), clear pending, counter=0, go to RUN.
  - New request while in WAIT overwrites pending only if its priority >= pending priority; otherwise it is dropped.
  - If an overwrite and go occur in the same cycle, the new winner is applied.
  - Counter increments each WAIT cycle with ihit=0, saturating at WAIT_MAX. Reaching WAIT_MAX sets fetch_timeout; it clears only on reset.
  - stall=1 with ihit=1 does not advance the counter.
- HALTED:
  - Entered from any state on halt=1. Halt wins over every request that cycle.
  - pc_en=0, imemREN=0, flushes 0, PCSrc=0, pending discarded.
  - Exit only by reset.
- imemREN=1 in RUN and WAIT.
- pc_en is never asserted when ihit=0 or stall=1.
- Exactly one PC write per applied redirect. Flushes are single-cycle, coincident with that write.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- When defined, adds outputs redirect_cnt[31:0] and miss_cycle_cnt[31:0]:
  - redirect_cnt counts applied redirects.
  - miss_cycle_cnt counts cycles with imemREN=1 and ihit=0.
  - Both reset to 0, wrap modulo 2^32, and freeze in HALTED.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ihit=1 stall=0 for 4 cycles -> PCSrc=0, pc_en=1 each cycle; no flushes; busy=0.
- RUN, ihit=1, j_req and br_req same cycle -> PCSrc=1, pc_en=1, if_flush=1, id_flush=1 that cycle only.
- RUN, jr_req with ihit=0 -> busy=1 next cycle. Hold ihit=0 for 3 cycles, then ihit=1 -> PCSrc=3, pc_en=1, if_flush=1, id_flush=0; busy=0 next cycle.
- Pending j (WAIT): br_req arrives -> pending becomes 1 and applies on the next ihit. Pending br, then j_req arrives -> j dropped, PCSrc=1 applied.
- WAIT_MAX=4, ihit held 0 in WAIT for 4 cycles -> fetch_timeout=1. It stays 1 after ihit returns; clears only on nRST=0.
- halt=1 with br_req=1 -> next cycle imemREN=0, pc_en=0, no flush. Assert nRST=0 asynchronously mid-cycle -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage redirect sequencer: drives PCSrc/pc_en, holds redirects across misses and stalls, emits IF/ID flushes.
// Optional performance counters are compiled in with the FETCH_SEQ_PERF_EN macro.
module fetch_sequencer #(
  parameter int WAIT_MAX = 64,
  parameter int CNT_W    = 7
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       stall,
  input  logic       halt,
  input  logic       br_req,
  input  logic       jr_req,
  input  logic       j_req,
  output logic [1:0] PCSrc,
  output logic       pc_en,
  output logic       imemREN,
  output logic       if_flush,
  output logic       id_flush,
  output logic       fetch_timeout,
  output logic       busy
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] miss_cycle_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [1:0]       SRC_PC4  = 2'd0;
  localparam logic [1:0]       SRC_BR   = 2'd1;
  localparam logic [1:0]       SRC_J    = 2'd2;
  localparam logic [1:0]       SRC_JR   = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state_r, state_nx;
  logic [1:0]       pend_r, pend_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic             timeout_r, timeout_nx;
  logic [1:0]       req_src_s, eff_src_s;
  logic             has_req_s, go_s;

  // Priority rank differs from the source encoding: br > jr > j.
  function automatic logic [1:0] rank(input logic [1:0] src);
    case (src)
      SRC_BR:  rank = 2'd3;
      SRC_JR:  rank = 2'd2;
      SRC_J:   rank = 2'd1;
      default: rank = 2'd0;
    endcase
  endfunction

  // Same-cycle request arbitration.
  always_comb begin
    has_req_s = br_req | jr_req | j_req;
    go_s      = ihit & ~stall;
    if (br_req) begin
      req_src_s = SRC_BR;
    end else if (jr_req) begin
      req_src_s = SRC_JR;
    end else if (j_req) begin
      req_src_s = SRC_J;
    end else begin
      req_src_s = SRC_PC4;
    end
    if (has_req_s && (rank(req_src_s) >= rank(pend_r))) begin
      eff_src_s = req_src_s;
    end else begin
      eff_src_s = pend_r;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nx   = state_r;
    pend_nx    = pend_r;
    cnt_nx     = cnt_r;
    timeout_nx = timeout_r;
    PCSrc      = SRC_PC4;
    pc_en      = 1'b0;
    imemREN    = 1'b1;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    busy       = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (halt) begin
          state_nx = ST_HALT;
          pend_nx  = SRC_PC4;
          cnt_nx   = CNT_ZERO;
        end else if (has_req_s && go_s) begin
          PCSrc    = req_src_s;
          pc_en    = 1'b1;
          if_flush = 1'b1;
          id_flush = (req_src_s == SRC_BR);
        end else if (has_req_s) begin
          pend_nx  = req_src_s;
          state_nx = ST_WAIT;
        end else begin
          pc_en = go_s;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (halt) begin
          state_nx = ST_HALT;
          pend_nx  = SRC_PC4;
          cnt_nx   = CNT_ZERO;
        end else if (go_s) begin
          PCSrc    = eff_src_s;
          pc_en    = 1'b1;
          if_flush = 1'b1;
          id_flush = (eff_src_s == SRC_BR);
          pend_nx  = SRC_PC4;
          cnt_nx   = CNT_ZERO;
          state_nx = ST_RUN;
        end else begin
          PCSrc   = eff_src_s;
          pend_nx = eff_src_s;
          // Only a missing fetch ages the wait; a stalled hit just holds.
          if (!ihit) begin
            if (cnt_r != CNT_MAX) begin
              cnt_nx = cnt_r + CNT_ONE;
            end else begin
              cnt_nx = cnt_r;
            end
            timeout_nx = timeout_r | (cnt_nx == CNT_MAX);
          end else begin
            cnt_nx = cnt_r;
          end
        end
      end
      ST_HALT: begin
        imemREN = 1'b0;
        pend_nx = SRC_PC4;
      end
      default: begin
        state_nx = ST_RUN;
        pend_nx  = SRC_PC4;
        cnt_nx   = CNT_ZERO;
      end
    endcase
    fetch_timeout = timeout_r;
  end

  // State, pending source, wait counter and sticky timeout.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= ST_RUN;
      pend_r    <= SRC_PC4;
      cnt_r     <= CNT_ZERO;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      pend_r    <= pend_nx;
      cnt_r     <= cnt_nx;
      timeout_r <= timeout_nx;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  // Performance counters; frozen once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      redirect_cnt   <= 32'd0;
      miss_cycle_cnt <= 32'd0;
    end else if (state_r != ST_HALT) begin
      if (if_flush) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
      if (imemREN && !ihit) begin
        miss_cycle_cnt <= miss_cycle_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed plan steps followed by random traffic against a reference model.
// Optional FETCH_SEQ_PERF_EN counters are checked when that macro is defined.
module tb_fetch_sequencer;
  localparam int WM = 4;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 1'b0, stall = 1'b0, halt = 1'b0;
  logic       br_req = 1'b0, jr_req = 1'b0, j_req = 1'b0;
  logic [1:0] PCSrc;
  logic       pc_en, imemREN, if_flush, id_flush, fetch_timeout, busy;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] redirect_cnt, miss_cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: "pending" is the waiting redirect (0 = none), no explicit FSM.
  int m_pend, m_cnt, cand_m;
  bit m_halted, m_to, go_m;
  int m_redir, m_miss;
  int e_src;
  bit e_pc, e_ren, e_if, e_id, e_busy;
  int obs_src;
  bit obs_pc, obs_ren, obs_if, obs_id, obs_to, obs_busy;

  fetch_sequencer #(.WAIT_MAX(WM), .CNT_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt(halt),
    .br_req(br_req), .jr_req(jr_req), .j_req(j_req),
    .PCSrc(PCSrc), .pc_en(pc_en), .imemREN(imemREN), .if_flush(if_flush),
    .id_flush(id_flush), .fetch_timeout(fetch_timeout), .busy(busy)
`ifdef FETCH_SEQ_PERF_EN
    , .redirect_cnt(redirect_cnt), .miss_cycle_cnt(miss_cycle_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int rank(input int s);
    case (s)
      1: return 3;
      3: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_pend = 0; m_cnt = 0; m_halted = 0; m_to = 0; m_redir = 0; m_miss = 0;
  endfunction

  function automatic void model_eval();
    int req;
    req = br_req ? 1 : jr_req ? 3 : j_req ? 2 : 0;
    go_m = ihit && !stall;
    cand_m = m_pend;
    if (req != 0 && rank(req) >= rank(m_pend)) cand_m = req;
    e_src = 0; e_pc = 0; e_if = 0; e_id = 0;
    e_ren = !m_halted;
    e_busy = !m_halted && (m_pend != 0);
    if (!m_halted && !halt) begin
      if (m_pend != 0) e_src = cand_m;
      if (go_m) begin
        e_pc = 1;
        if (cand_m != 0) begin
          e_src = cand_m; e_if = 1; e_id = (cand_m == 1);
        end
      end
    end
  endfunction

  function automatic void model_update();
    if (!m_halted) begin
      m_redir += int'(e_if);
      m_miss  += int'(e_ren && !ihit);
    end
    if (m_halted) begin
    end else if (halt) begin
      m_halted = 1; m_pend = 0; m_cnt = 0;
    end else if (go_m) begin
      m_pend = 0; m_cnt = 0;
    end else begin
      if (m_pend != 0 && !ihit) begin
        if (m_cnt < WM) m_cnt++;
        if (m_cnt == WM) m_to = 1;
      end
      m_pend = cand_m;
    end
  endfunction

  task automatic cycle(input logic h, input logic s, input logic hl,
                       input logic b, input logic r, input logic j);
    @(negedge CLK);
    ihit = h; stall = s; halt = hl; br_req = b; jr_req = r; j_req = j;
    #1;
    model_eval();
    obs_src = int'(PCSrc); obs_pc = pc_en; obs_ren = imemREN; obs_if = if_flush;
    obs_id = id_flush; obs_to = fetch_timeout; obs_busy = busy;
    chk("PCSrc", 32'(PCSrc), 32'(e_src));
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("imemREN", 32'(imemREN), 32'(e_ren));
    chk("if_flush", 32'(if_flush), 32'(e_if));
    chk("id_flush", 32'(id_flush), 32'(e_id));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("fetch_timeout", 32'(fetch_timeout), 32'(m_to));
`ifdef FETCH_SEQ_PERF_EN
    chk("redirect_cnt", redirect_cnt, 32'(m_redir));
    chk("miss_cycle_cnt", miss_cycle_cnt, 32'(m_miss));
`endif
    @(posedge CLK);
    model_update();
  endtask

  // Asynchronous reset mid-cycle with idle inputs; outputs must show reset values at once.
  task automatic do_reset();
    @(negedge CLK);
    ihit = 0; stall = 0; halt = 0; br_req = 0; jr_req = 0; j_req = 0;
    #1 nRST = 0;
    #1;
    chk("rst_PCSrc", 32'(PCSrc), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_imemREN", 32'(imemREN), 32'd1);
    chk("rst_if_flush", 32'(if_flush), 32'd0);
    chk("rst_id_flush", 32'(id_flush), 32'd0);
    chk("rst_fetch_timeout", 32'(fetch_timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge CLK);
    #2 nRST = 1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Plain sequential fetch.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      chk("seq_pc_en", 32'(obs_pc), 32'd1);
      chk("seq_flush", 32'(obs_if | obs_id), 32'd0);
    end

    // Branch beats jump in the same cycle.
    cycle(1, 0, 0, 1, 0, 1);
    chk("brj_PCSrc", 32'(obs_src), 32'd1);
    chk("brj_id_flush", 32'(obs_id), 32'd1);
    cycle(1, 0, 0, 0, 0, 0);
    chk("brj_flush_once", 32'(obs_if), 32'd0);

    // jr held across a miss.
    cycle(0, 0, 0, 0, 1, 0);
    chk("jr_no_pc_en", 32'(obs_pc), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("jr_busy", 32'(obs_busy), 32'd1);
    end
    cycle(1, 0, 0, 0, 0, 0);
    chk("jr_PCSrc", 32'(obs_src), 32'd3);
    chk("jr_id_flush", 32'(obs_id), 32'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("jr_busy_clear", 32'(obs_busy), 32'd0);
    chk("jr_no_timeout", 32'(obs_to), 32'd0);

    // Pending j overwritten by br.
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("ovr_PCSrc", 32'(obs_src), 32'd1);
    chk("ovr_id_flush", 32'(obs_id), 32'd1);

    // Pending br keeps priority over a later j.
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    chk("drop_PCSrc", 32'(obs_src), 32'd1);

    // Timeout after WM missing cycles in WAIT.
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < WM; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("to_set", 32'(obs_to), 32'd1);
    chk("to_PCSrc", 32'(obs_src), 32'd2);
    cycle(1, 0, 0, 0, 0, 0);
    chk("to_sticky", 32'(obs_to), 32'd1);

    // Halt wins over branch.
    cycle(1, 0, 1, 1, 0, 0);
    chk("halt_flush", 32'(obs_if | obs_id), 32'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("halt_imemREN", 32'(obs_ren), 32'd0);
    chk("halt_pc_en", 32'(obs_pc), 32'd0);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
              logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 4) == 0),
              logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
